// File: rtl/spi_debug_bridge_if.sv
// -----------------------------------------------------------------------------
// spi_debug_bridge_if
//   Bundles the board-level SPI pins and the system write port of the
//   SPI debug bridge.
//   Parameter AW : width of the write address.
//   Signals      : spi_mosi, spi_clk, spi_cs (host -> bridge, asynchronous)
//                  spi_miso (bridge -> host)
//                  wr_addr[AW-1:0], wr_data[15:0], wr, active (bridge -> system)
//   Modports     : slave  - the bridge itself
//                  master - the SPI host / system side
// -----------------------------------------------------------------------------
interface spi_debug_bridge_if #(
  parameter int AW = 16
);
  logic          spi_mosi;
  logic          spi_clk;
  logic          spi_cs;
  logic          spi_miso;
  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_data;
  logic          wr;
  logic          active;

  modport slave (
    input  spi_mosi, spi_clk, spi_cs,
    output spi_miso, wr_addr, wr_data, wr, active
  );

  modport master (
    output spi_mosi, spi_clk, spi_cs,
    input  spi_miso, wr_addr, wr_data, wr, active
  );
endinterface

// File: rtl/spi_debug_bridge.sv
// -----------------------------------------------------------------------------
// spi_debug_bridge
//   SPI mode-0 slave that turns host frames into 16-bit system writes.
//   The first 16 bits after cs falls are the address word; every further
//   16 bits is a data word, written to the current address, which then
//   increments (modulo 2^AW). MISO echoes the previous word (0x5A5A first).
//   SPI pins are oversampled by clk, so everything runs in the clk domain.
//
//   Ports:
//     clk   in  system clock
//     rst_n in  asynchronous active-low reset
//     bus   spi_debug_bridge_if.slave (SPI pins + write port + active)
//   Parameter AW (<= 16): write address width, low AW bits of the address word.
// -----------------------------------------------------------------------------
module spi_debug_bridge #(
  parameter int AW = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  spi_debug_bridge_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_e;

  localparam logic [15:0] LINK_MARKER = 16'h5A5A;

  // Synchronizers: two flops for metastability, a third on clk/cs for edges.
  logic [2:0] sclk_q;
  logic [2:0] cs_q;
  logic [1:0] mosi_q;

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q <= 3'b000;
      cs_q   <= 3'b111;
      mosi_q <= 2'b00;
    end else begin
      sclk_q <= {sclk_q[1:0], bus.spi_clk};
      cs_q   <= {cs_q[1:0],   bus.spi_cs};
      mosi_q <= {mosi_q[0],   bus.spi_mosi};
    end
  end

  logic sclk_rise, sclk_fall, cs_fall, cs_high, mosi_s;

  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  assign cs_fall   = ~cs_q[1] & cs_q[2];
  assign cs_high   = cs_q[1];
  assign mosi_s    = mosi_q[1];

  state_e        state_q;
  logic [3:0]    bit_cnt_q;
  logic [14:0]   rx_q;       // bits received so far in the current word
  logic [15:0]   tx_q;       // bits still to be shifted out on MISO
  logic          miso_q;
  logic [AW-1:0] wr_addr_q;
  logic [15:0]   wr_data_q;
  logic          wr_q;
  logic          active_q;
  logic [15:0]   word_d;     // word completed by the bit arriving this cycle

  assign word_d = {rx_q, mosi_s};

  // NOTE: every register here, datapath included, has an explicit reset value
  // so that a mid-transaction reset leaves no stale word or address behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= 4'd0;
      rx_q      <= '0;
      tx_q      <= '0;
      miso_q    <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_q      <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      wr_q <= 1'b0;
      // Post-write increment, one cycle after the strobe.
      if (wr_q) wr_addr_q <= wr_addr_q + AW'(1);

      case (state_q)
        IDLE: begin
          // A cs edge takes priority; clock edges in this cycle are ignored.
          if (cs_fall) begin
            state_q   <= ADDR;
            active_q  <= 1'b1;
            bit_cnt_q <= 4'd0;
            // The marker MSB must be on MISO before the first rising edge,
            // so it is presented now and the register holds what remains.
            miso_q    <= LINK_MARKER[15];
            tx_q      <= {LINK_MARKER[14:0], 1'b0};
          end
        end

        default: begin
          if (cs_high) begin
            // A partial word is simply dropped; wr_addr is left untouched.
            state_q  <= IDLE;
            active_q <= 1'b0;
          end else if (sclk_rise) begin
            rx_q      <= word_d[14:0];
            bit_cnt_q <= bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd15) begin
              // Echo the received word; its MSB goes out on the next falling edge.
              tx_q <= word_d;
              if (state_q == ADDR) begin
                wr_addr_q <= word_d[AW-1:0];
                state_q   <= DATA;
              end else begin
                wr_data_q <= word_d;
                wr_q      <= 1'b1;
              end
            end
          end else if (sclk_fall) begin
            miso_q <= tx_q[15];
            tx_q   <= {tx_q[14:0], 1'b0};
          end
        end
      endcase
    end
  end

  assign bus.spi_miso = miso_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign bus.wr       = wr_q;
  assign bus.active   = active_q;

endmodule

// File: tb/tb_spi_debug_bridge.sv
// -----------------------------------------------------------------------------
// tb_spi_debug_bridge
//   Drives SPI mode-0 frames into spi_debug_bridge and compares the write
//   strobes, MISO readback and final write address against a frame-level
//   model: word 0 is the address, word n (n >= 1) is written to address+n-1
//   (mod 2^16), MISO returns 0x5A5A then each previous word.
// -----------------------------------------------------------------------------
module tb_spi_debug_bridge;
  localparam int AW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  spi_debug_bridge_if #(.AW(AW)) bus ();

  spi_debug_bridge #(.AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] wr_log[$];       // observed {wr_addr, wr_data} per strobe
  int          dbl_wr = 0;      // strobes seen on back-to-back cycles
  logic        prev_wr = 1'b0;
  logic [15:0] frame_q[$];      // words of the frame being sent
  logic [15:0] rb_q[$];         // words read back on MISO
  logic [15:0] model_wr_addr = 16'h0000;

  always @(negedge clk) begin
    if (bus.wr) begin
      wr_log.push_back({bus.wr_addr, bus.wr_data});
      if (prev_wr) dbl_wr++;
    end
    prev_wr = bus.wr;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_frame(input int n, input logic [15:0] w0, input logic [15:0] w1,
                           input logic [15:0] w2, input logic [15:0] w3);
    frame_q.delete();
    if (n > 0) frame_q.push_back(w0);
    if (n > 1) frame_q.push_back(w1);
    if (n > 2) frame_q.push_back(w2);
    if (n > 3) frame_q.push_back(w3);
  endtask

  // One SPI bit: MOSI set while clock is low, MISO sampled just before the
  // rising edge. With 'timed', the write strobe is checked cycle by cycle.
  task automatic send_bit(input logic b, input int half, input bit timed,
                          input logic [15:0] ea, input logic [15:0] ed, output logic mb);
    bus.spi_mosi = b;
    repeat (half) @(negedge clk);
    mb = bus.spi_miso;
    bus.spi_clk = 1'b1;
    if (timed) begin
      @(negedge clk); check("wr_k1", bus.wr, 0);
      @(negedge clk); check("wr_k2", bus.wr, 0);
      @(negedge clk); check("wr_k3", {bus.wr, bus.wr_addr, bus.wr_data}, {1'b1, ea, ed});
      @(negedge clk); check("wr_k4", {bus.wr, bus.wr_addr}, {1'b0, ea + 16'd1});
      if (half > 4) repeat (half - 4) @(negedge clk);
    end else begin
      repeat (half) @(negedge clk);
    end
    bus.spi_clk = 1'b0;
  endtask

  task automatic run_frame(input int half, input int partial, input int timed_word);
    logic [15:0] rb, w, ea;
    logic        mb;
    rb = '0;
    rb_q.delete();
    bus.spi_cs = 1'b0;
    repeat (4) @(negedge clk);
    foreach (frame_q[i]) begin
      w  = frame_q[i];
      ea = frame_q[0] + 16'(i - 1);
      for (int b = 15; b >= 0; b--) begin
        send_bit(w[b], half, (i == timed_word) && (b == 0), ea, w, mb);
        rb = {rb[14:0], mb};
      end
      rb_q.push_back(rb);
    end
    for (int p = 0; p < partial; p++) send_bit(1'($urandom), half, 1'b0, 16'h0, 16'h0, mb);
    repeat (4) @(negedge clk);
    bus.spi_cs = 1'b1;
    @(negedge clk);
    @(negedge clk); check("active_hold", bus.active, 1);
    @(negedge clk); check("active_drop", bus.active, 0);
    repeat (6) @(negedge clk);
  endtask

  task automatic verify_frame(input string tag);
    int nw;
    nw = frame_q.size();
    check({tag, "_nwr"}, wr_log.size(), (nw > 0) ? nw - 1 : 0);
    for (int i = 1; i < nw; i++)
      if (wr_log.size() >= i)
        check({tag, "_wr"}, wr_log[i-1], {frame_q[0] + 16'(i - 1), frame_q[i]});
    for (int i = 0; i < nw; i++)
      check({tag, "_miso"}, rb_q[i], (i == 0) ? 16'h5A5A : frame_q[i-1]);
    if (nw > 0) model_wr_addr = frame_q[0] + 16'(nw - 1);
    check({tag, "_addr"}, bus.wr_addr, model_wr_addr);
    check({tag, "_dbl"}, dbl_wr, 0);
    wr_log.delete();
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    logic [15:0] w;
    logic        mb;
    int          n, partial;

    bus.spi_cs = 1'b1; bus.spi_clk = 1'b0; bus.spi_mosi = 1'b0;

    // Reset held with SPI pins toggling: outputs stay at reset values.
    for (int i = 0; i < 6; i++) begin
      repeat (2) @(negedge clk);
      bus.spi_clk  = ~bus.spi_clk;
      bus.spi_mosi = 1'($urandom);
      bus.spi_cs   = (i == 5) ? 1'b1 : 1'($urandom);
      check("reset_out", {bus.wr, bus.active, bus.spi_miso, bus.wr_addr, bus.wr_data}, 0);
    end
    bus.spi_cs = 1'b1;
    bus.spi_clk = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_after_reset", bus.active, 0);

    // Single write with cycle-level strobe timing on the data word.
    set_frame(2, 16'h0123, 16'hBEEF, 16'h0, 16'h0);
    run_frame(4, 0, 1);
    verify_frame("single");

    // Burst crossing the top of the address space.
    set_frame(4, 16'hFFFE, 16'h1111, 16'h2222, 16'h3333);
    run_frame(4, 0, -1);
    verify_frame("burst");

    // Loopback readback.
    set_frame(3, 16'h0010, 16'hA5C3, 16'h0F0F, 16'h0);
    run_frame(4, 0, -1);
    verify_frame("loop");

    // Aborted frame: address then 9 data bits, then a clean frame.
    set_frame(1, 16'h0040, 16'h0, 16'h0, 16'h0);
    run_frame(4, 9, -1);
    verify_frame("abort");
    set_frame(2, 16'h0050, 16'h7777, 16'h0, 16'h0);
    run_frame(4, 0, -1);
    verify_frame("after_abort");

    // Reset in the middle of a frame.
    bus.spi_cs = 1'b0;
    repeat (4) @(negedge clk);
    w = 16'h1234;
    for (int b = 15; b >= 0; b--) send_bit(w[b], 4, 1'b0, 16'h0, 16'h0, mb);
    for (int b = 0; b < 5; b++) send_bit(1'b1, 4, 1'b0, 16'h0, 16'h0, mb);
    check("pre_reset_addr", {bus.active, bus.wr_addr}, {1'b1, 16'h1234});
    rst_n = 1'b0;
    #1;
    check("mid_reset_out", {bus.wr, bus.active, bus.spi_miso, bus.wr_addr, bus.wr_data}, 0);
    bus.spi_cs = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      repeat (4) @(negedge clk);
      bus.spi_clk = ~bus.spi_clk;
    end
    repeat (4) @(negedge clk);
    check("idle_after_mid_reset", {bus.active, bus.wr_addr}, 0);
    model_wr_addr = 16'h0000;
    wr_log.delete();

    // Random frames at the maximum SPI rate (clk/6), some with partial tails.
    for (int f = 0; f < 25; f++) begin
      n = $urandom_range(1, 5);
      frame_q.delete();
      for (int i = 0; i < n; i++) frame_q.push_back(16'($urandom));
      partial = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 15) : 0;
      run_frame(3, partial, -1);
      verify_frame("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
